fc_argmax_reader: RTL and testbench
===================================

FC_ARGMAX_READER -- requirements
Module: fc_argmax_reader

Interface
REQ-001 SHALL have parameter N_ELEM, default 32, meaning the number of IEEE-754 single-precision elements in the input vector.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the width in bits of one element.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: global enable; when low, all state is frozen.
REQ-006 SHALL have port start, input, 1 bit: request to capture input_fc and begin a scan.
REQ-007 SHALL have port input_fc, input, N_ELEM*DATA_WIDTH (1024) bits: the activation-function output vector; element i occupies bits [32*i+31 : 32*i].
REQ-008 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse when a new result is valid.
REQ-010 SHALL have port max_index, output, 5 bits: index of the maximum element.
REQ-011 SHALL have port max_value, output, 32 bits: raw IEEE-754 bit pattern of the maximum element.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-013 IDLE: when en=1 and start=1 at edge T, SHALL capture input_fc into an internal 1024-bit register and enter SCAN.
REQ-014 SCAN: SHALL examine one element per enabled cycle, in index order 0..31, using a 5-bit counter.
REQ-015 The edge at T+1 SHALL load element 0 as the candidate; edges T+2..T+32 SHALL compare elements 1..31 against the candidate.
REQ-016 After element 31 is processed (edge T+32), SHALL enter DONE.
REQ-017 DONE: on edge T+33, SHALL copy the candidate into max_index/max_value, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-018 busy SHALL be 1 exactly while the state is SCAN or DONE.
REQ-019 When no stall occurs, latency from start to done SHALL be 33 cycles.
REQ-020 Comparison SHALL use IEEE-754 ordering: a positive value beats a negative value; among positives, the larger {exp,mantissa} wins; among negatives, the smaller {exp,mantissa} wins.
REQ-021 +0 and -0 SHALL compare equal.
REQ-022 A new element SHALL replace the candidate only if strictly greater; on ties the lowest index is kept.
REQ-023 NaN (exponent 0xFF with nonzero mantissa) SHALL rank below every non-NaN value, including -Inf.
REQ-024 A NaN element 0 SHALL be replaced by the first non-NaN element.
REQ-025 If all elements are NaN, the result SHALL be index 0 with the element-0 pattern.
REQ-026 +Inf and -Inf SHALL be ordered as ordinary extreme values.
REQ-027 start asserted while busy=1 SHALL be ignored; the captured vector SHALL NOT change during a scan.
REQ-028 en=0 in any state SHALL freeze the state, counter and candidate; a start with en=0 SHALL be ignored.
REQ-029 If en falls in the cycle done would pulse, done SHALL be delayed until the first cycle with en=1.
REQ-030 start asserted in the cycle after done (state IDLE) SHALL be accepted normally.
REQ-031 max_index/max_value SHALL hold their values between done pulses and change only at done.

Reset
REQ-032 reset=1 SHALL force, at the next edge: state IDLE, busy=0, done=0, max_index=0, max_value=0x00000000, counter=0, candidate cleared.
REQ-033 reset SHALL take priority over en and start.
REQ-034 Reset during SCAN or DONE SHALL abort the scan with no done pulse.

Verification
REQ-035 All elements 0x80000000 (-0.0), start -> done at T+33, max_index=0, max_value=0x80000000.
REQ-036 Element 7=0x40000000 (2.0), element 20=0x40400000 (3.0), others 0x3F800000 (1.0) -> max_index=20, max_value=0x40400000.
REQ-037 All elements negative, element 5=0xBF800000 (-1.0) the least negative, others 0xC0000000 (-2.0) -> max_index=5; also element 3=0x7FC00000 (NaN) and element 9=0x7F800000 (+Inf) -> max_index=9.
REQ-038 Elements 4 and 11 both 0x41200000 (10.0), other elements smaller -> max_index=4; start repeated mid-scan -> ignored, single done at T+33.
REQ-039 en low for 3 cycles mid-scan -> done at T+36, same result as without the stall.
REQ-040 reset asserted at T+10 -> no done pulse, outputs zero; a new start then completes normally.

Source files
------------

// File: rtl/fc_argmax_reader.sv
// fc_argmax_reader
//   Captures a vector of IEEE-754 single-precision activations and scans it
//   one element per enabled cycle, reporting the index and raw bit pattern of
//   the largest element. NaN ranks below everything; +0 and -0 are equal;
//   ties keep the lowest index.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-high reset, priority over everything
//   en         : global enable, when low all state is frozen
//   start      : capture input_fc and begin a scan (ignored while busy)
//   input_fc   : N_ELEM packed elements, element i at [DATA_WIDTH*i +: DATA_WIDTH]
//   busy       : high while scanning or waiting to publish the result
//   done       : one-cycle pulse when max_index/max_value are updated
//   max_index  : index of the maximum element
//   max_value  : raw bit pattern of the maximum element
module fc_argmax_reader #(
    parameter int N_ELEM     = 32,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         start,
    input  logic [N_ELEM*DATA_WIDTH-1:0] input_fc,
    output logic                         busy,
    output logic                         done,
    output logic [IDX_W-1:0]             max_index,
    output logic [DATA_WIDTH-1:0]        max_value
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    state_t                         state_r;
    logic [N_ELEM*DATA_WIDTH-1:0]   vec_r;
    logic [IDX_W-1:0]               cnt_r;
    logic [IDX_W-1:0]               cand_idx_r;
    logic [DATA_WIDTH-1:0]          cand_val_r;
    logic [IDX_W-1:0]               max_index_r;
    logic [DATA_WIDTH-1:0]          max_value_r;
    logic                           done_r;
    logic                           busy_r;
    logic [DATA_WIDTH-1:0]          elem_s;

    // NaN: all-ones exponent with a nonzero mantissa.
    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Strict IEEE ordering a > b with NaN below everything and +0 == -0.
    function automatic logic fp_greater(input logic [DATA_WIDTH-1:0] a,
                                        input logic [DATA_WIDTH-1:0] b);
        logic gt;
        if (is_nan(a)) begin
            gt = 1'b0;
        end else if (is_nan(b)) begin
            gt = 1'b1;
        end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
            gt = 1'b0;
        end else if (a[31] != b[31]) begin
            gt = ~a[31];
        end else if (a[31] == 1'b0) begin
            gt = (a[30:0] > b[30:0]);
        end else begin
            gt = (a[30:0] < b[30:0]);
        end
        return gt;
    endfunction

    assign elem_s = vec_r[int'(cnt_r)*DATA_WIDTH +: DATA_WIDTH];

    // Scan controller: capture, per-element compare, result publication.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            vec_r       <= {(N_ELEM*DATA_WIDTH){1'b0}};
            cnt_r       <= {IDX_W{1'b0}};
            cand_idx_r  <= {IDX_W{1'b0}};
            cand_val_r  <= {DATA_WIDTH{1'b0}};
            max_index_r <= {IDX_W{1'b0}};
            max_value_r <= {DATA_WIDTH{1'b0}};
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // done is a pulse; a stalled DONE state simply re-issues it later.
            done_r <= 1'b0;
            if (en) begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            vec_r   <= input_fc;
                            cnt_r   <= {IDX_W{1'b0}};
                            state_r <= SCAN;
                            busy_r  <= 1'b1;
                        end
                    end
                    SCAN: begin
                        // Element 0 is loaded unconditionally, even if NaN.
                        if (cnt_r == {IDX_W{1'b0}}) begin
                            cand_idx_r <= {IDX_W{1'b0}};
                            cand_val_r <= elem_s;
                        end else if (fp_greater(elem_s, cand_val_r)) begin
                            cand_idx_r <= cnt_r;
                            cand_val_r <= elem_s;
                        end
                        if (cnt_r == LAST_IDX) begin
                            cnt_r   <= {IDX_W{1'b0}};
                            state_r <= DONE;
                        end else begin
                            cnt_r <= cnt_r + IDX_W'(1);
                        end
                    end
                    DONE: begin
                        max_index_r <= cand_idx_r;
                        max_value_r <= cand_val_r;
                        done_r      <= 1'b1;
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign max_index = max_index_r;
    assign max_value = max_value_r;

endmodule

// File: tb/tb_fc_argmax_reader.sv
module tb_fc_argmax_reader;
    localparam int N = 32;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           start;
    logic [N*W-1:0] input_fc;
    logic           busy;
    logic           done;
    logic [4:0]     max_index;
    logic [31:0]    max_value;

    int          total = 0;
    int          bad   = 0;
    logic [4:0]  prev_idx;
    logic [31:0] prev_val;

    fc_argmax_reader #(.N_ELEM(N), .DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .input_fc(input_fc),
        .busy(busy), .done(done), .max_index(max_index), .max_value(max_value)
    );

    always #5 clk = ~clk;

    // Rank on a signed number line: NaN lowest, sign-magnitude folded to signed.
    function automatic longint rank(input logic [31:0] x);
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return -(longint'(1) << 40);
        if (x[31]) return -longint'(x[30:0]);
        return longint'(x[30:0]);
    endfunction

    function automatic int ref_idx(input logic [N*W-1:0] v);
        int best = 0;
        for (int i = 1; i < N; i++)
            if (rank(v[i*W +: W]) > rank(v[best*W +: W])) best = i;
        return best;
    endfunction

    function automatic logic [31:0] rand_elem();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
            5: return {s, 8'd127, 23'd0};
            6: return {s, 8'd128, 23'd0};
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [N*W-1:0] rand_vec(input bit specials);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = specials ? rand_elem() : $urandom();
        return v;
    endfunction

    function automatic logic [N*W-1:0] fill(input logic [31:0] x);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = x;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a scan and watch for done; lat = edges after the start edge, -1 on timeout.
    task automatic do_scan(input logic [N*W-1:0] v, input int stall_at, input int stall_len,
                           input int restart_at, output int lat, output logic [4:0] r_idx,
                           output logic [31:0] r_val, output logic first_done,
                           output logic [31:0] mid_val, output logic mid_busy);
        input_fc = v;
        en       = 1'b1;
        start    = 1'b1;
        step();
        first_done = done;
        start      = 1'b0;
        lat        = -1;
        mid_val    = 32'h0;
        mid_busy   = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            en       = !(k >= stall_at && k < stall_at + stall_len);
            start    = (k == restart_at);
            input_fc = rand_vec(1'b0);
            step();
            if (k == 5) begin
                mid_val  = max_value;
                mid_busy = busy;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        en    = 1'b1;
        r_idx = max_index;
        r_val = max_value;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        en       = 1'b1;
        start    = 1'b1;
        input_fc = rand_vec(1'b1);
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (max_index !== 5'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", max_index); end
        total++; if (max_value !== 32'h0) begin bad++; $display("FAIL reset_val got=%h exp=00000000", max_value); end
        reset = 1'b0;
        start = 1'b0;
        prev_idx = 5'd0;
        prev_val = 32'h0;
    endtask

    // One directed scan with full result checks against the reference model.
    task automatic test_vector(input string name, input logic [N*W-1:0] v, input int stall_at,
                               input int stall_len, input int restart_at, input int exp_lat);
        int lat; logic [4:0] ri; logic [31:0] rv; logic fd; logic [31:0] mv; logic mb;
        int ei; logic [31:0] ev;
        ei = ref_idx(v);
        ev = v[ei*W +: W];
        do_scan(v, stall_at, stall_len, restart_at, lat, ri, rv, fd, mv, mb);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat); end
        total++; if (ri !== 5'(ei)) begin bad++; $display("FAIL %s index got=%0d exp=%0d", name, ri, ei); end
        total++; if (rv !== ev) begin bad++; $display("FAIL %s value got=%h exp=%h", name, rv, ev); end
        total++; if (fd !== 1'b0) begin bad++; $display("FAIL %s done_early got=%0b exp=0", name, fd); end
        total++; if (mv !== prev_val) begin bad++; $display("FAIL %s held_value got=%h exp=%h", name, mv, prev_val); end
        total++; if (mb !== 1'b1) begin bad++; $display("FAIL %s busy_mid got=%0b exp=1", name, mb); end
        prev_idx = 5'(ei);
        prev_val = ev;
    endtask

    task automatic test_directed();
        logic [N*W-1:0] v;
        test_vector("neg_zero", fill(32'h8000_0000), 0, 0, 0, 33);
        total++; if (prev_idx !== 5'd0 || prev_val !== 32'h8000_0000) begin bad++; $display("FAIL neg_zero_model got=%0d/%h exp=0/80000000", prev_idx, prev_val); end
        v = fill(32'h3F80_0000);
        v[7*W +: W] = 32'h4000_0000;
        v[20*W +: W] = 32'h4040_0000;
        test_vector("positive", v, 0, 0, 0, 33);
        v = fill(32'hC000_0000);
        v[5*W +: W] = 32'hBF80_0000;
        test_vector("negative", v, 0, 0, 0, 33);
        v[3*W +: W] = 32'h7FC0_0000;
        v[9*W +: W] = 32'h7F80_0000;
        test_vector("nan_inf", v, 0, 0, 0, 33);
    endtask

    task automatic test_tie_restart();
        logic [N*W-1:0] v;
        v = fill(32'h4000_0000);
        v[4*W +: W] = 32'h4120_0000;
        v[11*W +: W] = 32'h4120_0000;
        test_vector("tie_restart", v, 0, 0, 10, 33);
    endtask

    task automatic test_stall();
        test_vector("stall", rand_vec(1'b1), 10, 3, 0, 36);
        test_vector("stall_done", rand_vec(1'b1), 33, 2, 0, 35);
    endtask

    task automatic test_nan();
        logic [N*W-1:0] v;
        v = fill(32'h7FC0_0001);
        v[0*W +: W] = 32'hFFC0_0000;
        test_vector("all_nan", v, 0, 0, 0, 33);
        v[6*W +: W] = 32'hFF80_0000;
        test_vector("nan_first", v, 0, 0, 0, 33);
        v = fill(32'h8000_0000);
        v[2*W +: W] = 32'h0000_0000;
        test_vector("zero_tie", v, 0, 0, 0, 33);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) test_vector("back_to_back", rand_vec(1'b1), 0, 0, 0, 33);
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        input_fc = rand_vec(1'b1);
        en       = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy got=%0b exp=0", busy); end
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL reset_mid_done got=%0d exp=0", ndone); end
        total++; if (max_index !== 5'd0) begin bad++; $display("FAIL reset_mid_idx got=%0d exp=0", max_index); end
        total++; if (max_value !== 32'h0) begin bad++; $display("FAIL reset_mid_val got=%h exp=00000000", max_value); end
        prev_idx = 5'd0;
        prev_val = 32'h0;
        test_vector("after_reset", rand_vec(1'b1), 0, 0, 0, 33);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) test_vector("random", rand_vec(i % 4 != 3), 0, 0, 0, 33);
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        start    = 1'b0;
        input_fc = '0;
        test_reset();
        test_directed();
        test_tie_restart();
        test_stall();
        test_nan();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
